// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if: duty write port (valid/ready, channel, high time) with master/slave views
interface pwm_multi_channel_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 17
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic wr_valid;
  logic wr_ready;
  logic [CH_W-1:0] wr_ch;
  logic [CNT_W-1:0] wr_duty;
  modport master (output wr_valid, wr_ch, wr_duty, input wr_ready);
  modport slave (input wr_valid, wr_ch, wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel PWM, shared period counter, shadowed duty committed at period end, arm/failsafe watchdog
module pwm_multi_channel #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 17,
  parameter int PERIOD = 106400,
  parameter int MIN_HI = 33200,
  parameter int MAX_HI = 103200,
  parameter int FAILSAFE_HI = 33200,
  parameter int TIMEOUT_PER = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  pwm_multi_channel_if.slave wr,
  output logic [NUM_CH-1:0] pwm_out,
  output logic period_start,
  output logic armed,
  output logic failsafe,
  output logic bad_ch
);
  localparam int WD_W = $clog2(TIMEOUT_PER + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LO = CNT_W'(MIN_HI);
  localparam logic [CNT_W-1:0] HI = CNT_W'(MAX_HI);
  localparam logic [CNT_W-1:0] FS = CNT_W'(FAILSAFE_HI);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_PER);
  typedef enum logic [1:0] {DISARMED, ARMED, FAILSAFE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, duty;
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] active [NUM_CH];
  logic [WD_W-1:0] wd;
  logic boundary, accept, ch_ok;
  always_comb begin
    boundary = cnt == LAST;
    cnt_nxt = boundary ? '0 : cnt + CNT_W'(1);
    accept = wr.wr_valid & wr.wr_ready;
    ch_ok = 32'(wr.wr_ch) < NUM_CH;
    duty = wr.wr_duty < LO ? LO : wr.wr_duty > HI ? HI : wr.wr_duty;
    state_nxt = !boundary ? state :
                !arm ? DISARMED :
                state == DISARMED ? ARMED :
                (state == ARMED && wd >= WD_MAX) ? FAILSAFE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      state <= DISARMED;
      wd <= '0;
      wr.wr_ready <= 1'b0;
      pwm_out <= '0;
      period_start <= 1'b0;
      armed <= 1'b0;
      failsafe <= 1'b0;
      bad_ch <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= FS;
        active[i] <= FS;
      end
    end else begin
      cnt <= cnt_nxt;
      state <= state_nxt;
      wr.wr_ready <= cnt_nxt != LAST;
      period_start <= cnt == '0;
      armed <= state_nxt == ARMED;
      failsafe <= state_nxt == FAILSAFE;
      bad_ch <= accept & !ch_ok;
      wd <= (state_nxt != ARMED || accept) ? '0 :
            (boundary && state == ARMED && wd < WD_MAX) ? wd + WD_W'(1) : wd;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && ch_ok && 32'(wr.wr_ch) == i) shadow[i] <= duty;
        if (boundary) active[i] <= state_nxt == ARMED ? shadow[i] : FS;
        pwm_out[i] <= cnt < active[i];
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed + randomized periods checked against a per-period behavioural model
module tb_pwm_multi_channel;
  localparam int PERIOD = 100;
  localparam int FS_HI = 20;
  localparam int TO = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0;
  logic [3:0] pwm_out;
  logic period_start, armed, failsafe, bad_ch;
  logic [2:0] pwm_b;
  logic ps_b, armed_b, fs_b, bad_b;
  int errors = 0;
  int checks = 0;
  int st, since, k;
  int shadow [4];
  int act [4];
  pwm_multi_channel_if #(.NUM_CH(4), .CNT_W(8)) wr ();
  pwm_multi_channel_if #(.NUM_CH(3), .CNT_W(8)) wrb ();
  pwm_multi_channel #(
    .NUM_CH(4), .CNT_W(8), .PERIOD(PERIOD), .MIN_HI(20), .MAX_HI(90),
    .FAILSAFE_HI(FS_HI), .TIMEOUT_PER(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .wr(wr), .pwm_out(pwm_out),
    .period_start(period_start), .armed(armed), .failsafe(failsafe), .bad_ch(bad_ch)
  );
  pwm_multi_channel #(
    .NUM_CH(3), .CNT_W(8), .PERIOD(PERIOD), .MIN_HI(20), .MAX_HI(90),
    .FAILSAFE_HI(FS_HI), .TIMEOUT_PER(TO)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .arm(1'b0), .wr(wrb), .pwm_out(pwm_b),
    .period_start(ps_b), .armed(armed_b), .failsafe(fs_b), .bad_ch(bad_b)
  );
  always #5 clk = ~clk;
  function automatic int clamp(input int d);
    return d < 20 ? 20 : d > 90 ? 90 : d;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    st = 0;
    since = 0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      shadow[i] = FS_HI;
      act[i] = FS_HI;
    end
  endtask
  // One period, phase 0 = the cycle period_start is high; phase 98 is the boundary cycle.
  task automatic run_period(input bit arm_v, input int arm_p = 0, input int w_p = -1,
                            input int w_ch = 0, input int w_duty = 0, input int b_p = -1,
                            input int rst_p = -1);
    int hi [4];
    int shape [4];
    int ps_bad, rdy_bad, nbad_b, nbad, exp_bad_b, hib;
    bit arm_b;
    logic [3:0] ev;
    ps_bad = 0; rdy_bad = 0; nbad_b = 0; nbad = 0; exp_bad_b = 0; hib = 0; arm_b = 0;
    for (int i = 0; i < 4; i++) begin
      hi[i] = 0;
      shape[i] = 0;
    end
    for (int p = 0; p < PERIOD; p++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        ev[i] = p < act[i];
        hi[i] += int'(pwm_out[i]);
        if (pwm_out[i] !== ev[i]) shape[i]++;
      end
      for (int i = 0; i < 3; i++) hib += int'(pwm_b[i]);
      if (period_start !== (p == 0) || ps_b !== (p == 0)) ps_bad++;
      if (wr.wr_ready !== (p != PERIOD - 2)) rdy_bad++;
      nbad_b += int'(bad_b);
      nbad += int'(bad_ch);
      if (p == 0) begin
        check("armed", armed, st == 1);
        check("failsafe", failsafe, st == 2);
        check("b_state", {armed_b, fs_b}, 0);
      end
      if (p == rst_p) begin
        check("pwm_pre_rst", pwm_out, ev);
        rst_n = 1'b0;
        #1;
        check("pwm_async_rst", pwm_out, 0);
        return;
      end
      if (p == arm_p) arm = arm_v;
      wr.wr_valid = p == w_p;
      wr.wr_ch = w_ch[1:0];
      wr.wr_duty = w_duty[7:0];
      wrb.wr_valid = p == b_p;
      wrb.wr_ch = 2'd3;
      wrb.wr_duty = 8'd50;
      if (p == w_p && p != PERIOD - 2) begin
        shadow[w_ch] = clamp(w_duty);
        since = k;
      end
      if (p == b_p && p != PERIOD - 2) exp_bad_b++;
      if (p == PERIOD - 2) arm_b = arm;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hi_ch%0d_p%0d", i, k), hi[i], act[i]);
      check($sformatf("shape_ch%0d_p%0d", i, k), shape[i], 0);
    end
    check("period_start", ps_bad, 0);
    check("wr_ready", rdy_bad, 0);
    check("bad_ch_b", nbad_b, exp_bad_b);
    check("bad_ch_main", nbad, 0);
    check("b_hi_total", hib, 3 * FS_HI);
    if (!arm_b) st = 0;
    else if (st == 0) begin
      st = 1;
      since = k + 1;
    end else if (st == 1 && k - since >= TO) st = 2;
    for (int i = 0; i < 4; i++) act[i] = st == 1 ? shadow[i] : FS_HI;
    k++;
  endtask
  initial begin
    int r, d;
    wr.wr_valid = 1'b0; wr.wr_ch = '0; wr.wr_duty = '0;
    wrb.wr_valid = 1'b0; wrb.wr_ch = '0; wrb.wr_duty = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outputs", {pwm_out, wr.wr_ready, period_start, armed, failsafe, bad_ch}, 0);
    rst_n = 1'b1;
    run_period(0);
    run_period(0, 0, -1, 0, 0, 98);
    run_period(1, 0, 9, 2, 50);
    run_period(1, 0, $urandom_range(0, 97), 0, 5, 40);
    run_period(1, 0, $urandom_range(0, 97), 1, 200);
    for (int n = 0; n < 3; n++)
      run_period(1, 0, $urandom_range(0, 97), $urandom_range(0, 1), $urandom_range(0, 255));
    run_period(1, 0, 98, 3, 70);
    run_period(1);
    run_period(1);
    run_period(1, 0, 30, 3, 80);
    run_period(0, 0, 10, 2, 50);
    run_period(1);
    run_period(1, 29);
    run_period(0, 50, 60, 2, 50);
    run_period(1, 0, 10, 2, 50, -1, 24);
    repeat (3) @(negedge clk);
    check("rst_outputs2", {pwm_out, wr.wr_ready, period_start, armed, failsafe, bad_ch}, 0);
    arm = 1'b0;
    wr.wr_valid = 1'b0;
    model_reset();
    rst_n = 1'b1;
    run_period(0);
    run_period(0, 0, 50, 1, 255);
    for (int n = 0; n < 8; n++) begin
      r = $urandom_range(0, 9);
      d = r == 0 ? 0 : r == 1 ? 255 : $urandom_range(0, 255);
      run_period($urandom_range(0, 4) != 0, $urandom_range(0, 98), $urandom_range(0, 98),
                 $urandom_range(0, 3), d, $urandom_range(0, 1) != 0 ? $urandom_range(0, 96) : -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
